// File: rtl/upg_pkg.sv
// Shared types and constants for the UART programming controller.
package upg_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PG_ARM  = 2'd1,
    PG_LOAD = 2'd2,
    PG_DONE = 2'd3
  } upg_state_e;

  localparam int UPG_SEL_BIT = 14;
  localparam int UPG_ADDR_W  = 14;
  localparam int UPG_DATA_W  = 32;

  // One programming write as it arrives from the UART programmer.
  typedef struct packed {
    logic                  sel;   // 0 = IMEM, 1 = DMEM
    logic [UPG_ADDR_W-1:0] addr;
    logic [UPG_DATA_W-1:0] data;
  } upg_wr_t;

  // Width of a counter that must hold values 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-level debouncer and
// a single-cycle pulse on each accepted rising edge.
module btn_debounce
  import upg_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int DW = cnt_width(DEB_CYCLES);

  logic [1:0]    sync;
  logic          level;
  logic [DW-1:0] cnt;

  // Bring the raw button into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], btn};
  end

  // Accept a new level only after it differed from the current one for
  // DEB_CYCLES consecutive cycles; pulse when the accepted level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == DW'(DEB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        pulse <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_prog_ctrl.sv
// RUN / UART-programming sequencer with IMEM/DMEM write steering.
// Optional idle-write timeout in PG_LOAD is built when UPG_TIMEOUT_EN
// is defined; otherwise PG_LOAD waits for upg_done_o and pg_err is 0.
module uart_prog_ctrl
  import upg_pkg::*;
#(
  parameter int DEB_CYCLES     = 1_000_000,
  parameter int RST_HOLD       = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_pg,
  input  logic                  upg_wen_o,
  input  logic                  upg_done_o,
  input  logic [14:0]           upg_adr_o,
  input  logic [31:0]           upg_dat_o,
  output logic                  upg_rst,
  output logic                  cpu_rst_n,
  output logic                  prog_mode,
  output logic                  imem_upg_we,
  output logic                  dmem_upg_we,
  output logic [UPG_ADDR_W-1:0] upg_waddr,
  output logic [31:0]           upg_wdata,
  output logic [CNT_W-1:0]      word_cnt,
  output logic                  pg_err
);

  localparam int HW = cnt_width(RST_HOLD);

  upg_state_e    state, state_nxt;
  logic          pg_req;
  logic [HW-1:0] hold_cnt;
  logic          load, wr_fire, timeout;
  logic          cpu_rst_n_nxt, upg_rst_nxt, prog_mode_nxt;
  upg_wr_t       wr_in;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk   (clk),
    .rst_n (rst),
    .btn   (start_pg),
    .pulse (pg_req)
  );

  assign wr_in.sel  = upg_adr_o[UPG_SEL_BIT];
  assign wr_in.addr = upg_adr_o[UPG_ADDR_W-1:0];
  assign wr_in.data = upg_dat_o;

  assign load    = (state == PG_LOAD);
  assign wr_fire = load & upg_wen_o;

  // State and control outputs; outputs are registered from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      cpu_rst_n <= 1'b0;
      upg_rst   <= 1'b1;
      prog_mode <= 1'b0;
    end else begin
      state     <= state_nxt;
      cpu_rst_n <= cpu_rst_n_nxt;
      upg_rst   <= upg_rst_nxt;
      prog_mode <= prog_mode_nxt;
    end
  end

  // Next state and next control-output values.
  always_comb begin
    state_nxt     = state;
    cpu_rst_n_nxt = 1'b0;
    upg_rst_nxt   = 1'b1;
    prog_mode_nxt = 1'b0;
    case (state)
      RUN:     if (pg_req) state_nxt = PG_ARM;
      PG_ARM:  state_nxt = PG_LOAD;
      PG_LOAD: if (upg_done_o || timeout) state_nxt = PG_DONE;
      PG_DONE: if (hold_cnt == HW'(RST_HOLD - 1)) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    case (state_nxt)
      RUN:            cpu_rst_n_nxt = 1'b1;
      PG_ARM,
      PG_LOAD: begin
        upg_rst_nxt   = 1'b0;
        prog_mode_nxt = 1'b1;
      end
      // Keep the memories on the programming port for the first PG_DONE
      // cycle so a write strobed alongside upg_done_o still lands.
      PG_DONE:        prog_mode_nxt = (state == PG_LOAD);
      default:        cpu_rst_n_nxt = 1'b0;
    endcase
  end

  // Counts cycles spent in PG_DONE to time the CPU reset hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  hold_cnt <= '0;
    else if (state == PG_DONE) hold_cnt <= hold_cnt + 1'b1;
    else                       hold_cnt <= '0;
  end

  // Steer programmer writes to IMEM or DMEM one cycle after the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_upg_we <= 1'b0;
      dmem_upg_we <= 1'b0;
      upg_waddr   <= '0;
      upg_wdata   <= '0;
    end else begin
      imem_upg_we <= wr_fire & ~wr_in.sel;
      dmem_upg_we <= wr_fire &  wr_in.sel;
      if (wr_fire) begin
        upg_waddr <= wr_in.addr;
        upg_wdata <= wr_in.data;
      end
    end
  end

  // Session word counter: cleared on an accepted request, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            word_cnt <= '0;
    else if (state == RUN && pg_req)     word_cnt <= '0;
    else if (wr_fire && word_cnt != '1)  word_cnt <= word_cnt + 1'b1;
  end

`ifdef UPG_TIMEOUT_EN
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_cnt;

  assign timeout = load && !upg_wen_o && !upg_done_o &&
                   (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Idle cycles since entering PG_LOAD or since the last write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    idle_cnt <= '0;
    else if (!load || upg_wen_o) idle_cnt <= '0;
    else                         idle_cnt <= idle_cnt + 1'b1;
  end

  // Sticky timeout flag, cleared by the next accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        pg_err <= 1'b0;
    else if (state == RUN && pg_req) pg_err <= 1'b0;
    else if (timeout)                pg_err <= 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign pg_err         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_prog_ctrl.sv
// Scoreboard bench for uart_prog_ctrl: stimulus pushes expected writes,
// a monitor pops and compares whenever a programming write appears.
module tb_uart_prog_ctrl;

  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start_pg = 1'b0;
  logic              upg_wen_o = 1'b0;
  logic              upg_done_o = 1'b0;
  logic [14:0]       upg_adr_o = '0;
  logic [31:0]       upg_dat_o = '0;
  logic              upg_rst, cpu_rst_n, prog_mode, imem_upg_we, dmem_upg_we, pg_err;
  logic [13:0]       upg_waddr;
  logic [31:0]       upg_wdata;
  logic [CNT_W-1:0]  word_cnt;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic             dmem;
    logic [13:0]      addr;
    logic [31:0]      data;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  uart_prog_ctrl #(
    .DEB_CYCLES(4), .RST_HOLD(4), .TIMEOUT_CYCLES(16), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start_pg(start_pg), .upg_wen_o(upg_wen_o),
    .upg_done_o(upg_done_o), .upg_adr_o(upg_adr_o), .upg_dat_o(upg_dat_o),
    .upg_rst(upg_rst), .cpu_rst_n(cpu_rst_n), .prog_mode(prog_mode),
    .imem_upg_we(imem_upg_we), .dmem_upg_we(dmem_upg_we), .upg_waddr(upg_waddr),
    .upg_wdata(upg_wdata), .word_cnt(word_cnt), .pg_err(pg_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Drive one write strobe and record what should come out of the DUT.
  task automatic wr(input logic [14:0] a, input logic [31:0] d, input logic [CNT_W-1:0] c);
    exp_t e;
    e.dmem = a[14];
    e.addr = a[13:0];
    e.data = d;
    e.cnt  = c;
    q.push_back(e);
    upg_wen_o = 1'b1;
    upg_adr_o = a;
    upg_dat_o = d;
  endtask

  // Debounced press from RUN: expect PG_ARM 7 negedges after start_pg rises
  // (2 sync + 4 stable + 1 pulse register); returns with the DUT in PG_LOAD.
  task automatic press(input string name);
    int n;
    n = 0;
    tick(8);
    start_pg = 1'b1;
    do begin
      tick();
      n++;
    end while (!prog_mode && n < 20);
    chk({name, "_arm_latency"}, n, 7);
    chk({name, "_arm_cpu_rst_n"}, cpu_rst_n, 0);
    chk({name, "_arm_upg_rst"}, upg_rst, 0);
    tick(3);
    start_pg = 1'b0;
  endtask

  // Monitor: every programming write must match the head of the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_upg_we || dmem_upg_we) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_we: imem=%0b dmem=%0b addr=%0h required no write",
                   imem_upg_we, dmem_upg_we, upg_waddr);
        end else begin
          mon_e = q.pop_front();
          if ({dmem_upg_we, imem_upg_we, upg_waddr, upg_wdata, word_cnt} !==
              {mon_e.dmem, ~mon_e.dmem, mon_e.addr, mon_e.data, mon_e.cnt}) begin
            fails++;
            $display("FAIL write: got d=%0b i=%0b a=%0h d=%0h cnt=%0d expected d=%0b a=%0h d=%0h cnt=%0d",
                     dmem_upg_we, imem_upg_we, upg_waddr, upg_wdata, word_cnt,
                     mon_e.dmem, mon_e.addr, mon_e.data, mon_e.cnt);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset
    tick(3);
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    chk("rst_upg_rst", upg_rst, 1);
    chk("rst_prog_mode", prog_mode, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_waddr_wdata", {upg_waddr, upg_wdata} == '0, 1);
    chk("rst_pg_err", pg_err, 0);
    rst = 1'b1;
    tick();
    chk("run_cpu_rst_n", cpu_rst_n, 1);
    chk("run_upg_rst", upg_rst, 1);

    // 2. short press is filtered
    start_pg = 1'b1;
    tick(2);
    start_pg = 1'b0;
    begin
      int armed;
      armed = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (prog_mode || !cpu_rst_n) armed = 1;
      end
      chk("short_press_ignored", armed, 0);
    end

    press("s1");
    chk("load_prog_mode", prog_mode, 1);

    // 3. IMEM then DMEM write
    wr(15'h0003, 32'hDEADBEEF, 1);
    tick();
    wr(15'h4005, 32'h12345678, 2);
    tick();
    upg_wen_o = 1'b0;
    tick();
    chk("load_word_cnt", word_cnt, 2);
    chk("load_cpu_rst_n", cpu_rst_n, 0);

    // 4. write in the same cycle as done, then reset hold
    wr(15'h0007, 32'hCAFEF00D, 3);
    upg_done_o = 1'b1;
    tick();
    upg_wen_o  = 1'b0;
    upg_done_o = 1'b0;
    chk("done_prog_mode_first", prog_mode, 1);
    chk("done_upg_rst", upg_rst, 1);
    tick();
    chk("done_prog_mode_second", prog_mode, 0);
    tick(2);
    chk("done_cpu_rst_n_hold", cpu_rst_n, 0);
    tick();
    chk("done_back_to_run", cpu_rst_n, 1);
    chk("done_word_cnt", word_cnt, 3);

    // 5. wen in RUN and press during PG_LOAD are ignored
    upg_wen_o = 1'b1;
    upg_adr_o = 15'h0009;
    tick();
    upg_wen_o = 1'b0;
    chk("run_wen_no_we", imem_upg_we | dmem_upg_we, 0);
    tick();
    chk("run_wen_word_cnt", word_cnt, 3);

    press("s2");
    chk("s2_word_cnt_cleared", word_cnt, 0);
    wr(15'h400A, 32'h0BADF00D, 1);
    tick();
    upg_wen_o = 1'b0;
    tick(8);
    start_pg = 1'b1;
    tick(10);
    start_pg = 1'b0;
    chk("load_press_prog_mode", prog_mode, 1);
    chk("load_press_word_cnt", word_cnt, 1);
    upg_done_o = 1'b1;
    tick();
    upg_done_o = 1'b0;
    tick(5);
    chk("s2_back_to_run", cpu_rst_n, 1);

`ifdef UPG_TIMEOUT_EN
    // 6. idle timeout
    press("s3");
    begin
      int n;
      n = 0;
      while (!upg_rst && n < 40) begin
        tick();
        n++;
      end
      chk("timeout_reached", upg_rst, 1);
    end
    chk("timeout_pg_err", pg_err, 1);
    tick(5);
    chk("timeout_run", cpu_rst_n, 1);
    chk("timeout_err_sticky", pg_err, 1);
    press("s4");
    chk("timeout_err_cleared", pg_err, 0);
    upg_done_o = 1'b1;
    tick();
    upg_done_o = 1'b0;
    tick(5);
`else
    chk("pg_err_tied", pg_err, 0);
`endif

    // rst mid-session
    press("s5");
    wr(15'h0011, 32'hA5A5A5A5, 1);
    tick();
    upg_wen_o = 1'b0;
    tick(2);
    rst = 1'b0;
    #1;
    chk("abort_cpu_rst_n", cpu_rst_n, 0);
    chk("abort_upg_rst", upg_rst, 1);
    chk("abort_prog_mode", prog_mode, 0);
    chk("abort_word_cnt", word_cnt, 0);
    chk("abort_pg_err", pg_err, 0);
    tick();
    rst = 1'b1;
    tick(2);
    chk("abort_release", cpu_rst_n, 1);
    chk("scoreboard_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
